dram_req_scheduler: RTL and testbench

Front-end scheduler for dram_ctrl_fsm. It arbitrates round-robin among NUM_REQ address requesters and a periodic refresh timer. It registers the winning bank/row/col and drives the FSM's addr_val, bank_id, row_id, col_id and refresh_flag inputs. The block holds a command until the controller reports completion, then hands the FSM to the next requester.

---
 rtl/dram_ctrl_pkg.sv | 19 +
 rtl/dram_rr_arbiter.sv | 51 +++++
 rtl/dram_req_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_dram_req_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_ctrl_pkg.sv
// Shared types and default geometry for the DRAM controller front end.
// The scheduler and arbiter import this package.
package dram_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_REFRESH
   } sched_state_e;

   localparam int DEF_BANKS = 8;
   localparam int DEF_ROWS  = 128;
   localparam int DEF_COLS  = 8;

   localparam int BW = $clog2(DEF_BANKS);
   localparam int RW = $clog2(DEF_ROWS);
   localparam int CW = $clog2(DEF_COLS);

endpackage

// File: rtl/dram_rr_arbiter.sv
// Round-robin arbiter with its own rotating pointer.
// The pointer moves one past the winner whenever update_en accepts a grant.
module dram_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_b,
   input  logic [NUM_REQ-1:0] req_val,
   input  logic               update_en,
   output logic [NUM_REQ-1:0] winner_oh,
   output logic [IW-1:0]      winner_idx
);

   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic          found;
   int            idx;

   // The search starts at rr_ptr and wraps explicitly, so NUM_REQ need not be a power of two.
   always_comb begin
      winner_oh  = '0;
      winner_idx = '0;
      found      = 1'b0;
      idx        = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!found && req_val[IW'(idx)]) begin
            found      = 1'b1;
            winner_idx = IW'(idx);
         end
      end
      winner_oh[winner_idx] = found;

      rr_ptr_d = rr_ptr_q;
      if (update_en && found) begin
         rr_ptr_d = (winner_idx == IW'(NUM_REQ - 1)) ? '0 : winner_idx + IW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: rtl/dram_req_scheduler.sv
// Front-end scheduler for dram_ctrl_fsm: round-robin address requests plus periodic refresh.
// A command is held on the address outputs until cmd_done, with an IDLE cycle between jobs.
module dram_req_scheduler
   import dram_ctrl_pkg::*;
#(
   parameter  int NUMBER_OF_BANKS  = DEF_BANKS,
   parameter  int NUMBER_OF_ROWS   = DEF_ROWS,
   parameter  int NUMBER_OF_COLS   = DEF_COLS,
   parameter  int NUM_REQ          = 4,
   parameter  int REFRESH_INTERVAL = 1024,
   parameter  int REFRESH_CYCLES   = 16,
   localparam int BANK_W           = $clog2(NUMBER_OF_BANKS),
   localparam int ROW_W            = $clog2(NUMBER_OF_ROWS),
   localparam int COL_W            = $clog2(NUMBER_OF_COLS),
   localparam int GID_W            = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_b,
   input  logic [NUM_REQ-1:0]        req_val,
   input  logic [NUM_REQ*BANK_W-1:0] req_bank,
   input  logic [NUM_REQ*ROW_W-1:0]  req_row,
   input  logic [NUM_REQ*COL_W-1:0]  req_col,
   output logic [NUM_REQ-1:0]        req_gnt,
   input  logic                      cmd_done,
   output logic                      addr_val,
   output logic [BANK_W-1:0]         bank_id,
   output logic [ROW_W-1:0]          row_id,
   output logic [COL_W-1:0]          col_id,
   output logic                      refresh_flag,
   output logic [GID_W-1:0]          grant_id,
   output logic                      refresh_overrun
);

   localparam int TW = $clog2(REFRESH_INTERVAL);
   localparam int HW = $clog2(REFRESH_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_RELOAD = TW'(REFRESH_INTERVAL - 1);
   localparam logic [HW-1:0] HOLD_INIT    = HW'(REFRESH_CYCLES - 1);

   sched_state_e         state_q, state_d;
   logic                 addr_val_q, addr_val_d;
   logic [BANK_W-1:0]    bank_q, bank_d;
   logic [ROW_W-1:0]     row_q, row_d;
   logic [COL_W-1:0]     col_q, col_d;
   logic [GID_W-1:0]     grant_id_q, grant_id_d;
   logic [NUM_REQ-1:0]   req_gnt_q, req_gnt_d;
   logic                 refresh_flag_q, refresh_flag_d;
   logic                 overrun_q, overrun_d;
   logic                 pending_q, pending_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [HW-1:0]        hold_q, hold_d;

   logic [NUM_REQ-1:0]   winner_oh;
   logic [GID_W-1:0]     winner_idx;
   logic                 arb_update;
   logic                 consume;
   logic                 expire;
   logic [BANK_W-1:0]    bank_sel;
   logic [ROW_W-1:0]     row_sel;
   logic [COL_W-1:0]     col_sel;

   dram_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk        (clk),
      .rst_b      (rst_b),
      .req_val    (req_val),
      .update_en  (arb_update),
      .winner_oh  (winner_oh),
      .winner_idx (winner_idx)
   );

   always_comb begin
      bank_sel = '0;
      row_sel  = '0;
      col_sel  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner_oh[i]) begin
            bank_sel = req_bank[i*BANK_W +: BANK_W];
            row_sel  = req_row[i*ROW_W +: ROW_W];
            col_sel  = req_col[i*COL_W +: COL_W];
         end
      end
   end

   // Refresh is only taken from IDLE, so a pending refresh never interrupts a command.
   always_comb begin
      state_d        = state_q;
      addr_val_d     = addr_val_q;
      bank_d         = bank_q;
      row_d          = row_q;
      col_d          = col_q;
      grant_id_d     = grant_id_q;
      req_gnt_d      = '0;
      refresh_flag_d = refresh_flag_q;
      hold_d         = hold_q;
      arb_update     = 1'b0;
      consume        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pending_q) begin
               state_d        = ST_REFRESH;
               refresh_flag_d = 1'b1;
               hold_d         = HOLD_INIT;
               consume        = 1'b1;
            end else if (|req_val) begin
               state_d    = ST_ISSUE;
               addr_val_d = 1'b1;
               bank_d     = bank_sel;
               row_d      = row_sel;
               col_d      = col_sel;
               grant_id_d = winner_idx;
               req_gnt_d  = winner_oh;
               arb_update = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (cmd_done) begin
               addr_val_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         ST_REFRESH: begin
            if (hold_q == '0) begin
               refresh_flag_d = 1'b0;
               state_d        = ST_IDLE;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      expire    = (timer_q == '0);
      timer_d   = expire ? TIMER_RELOAD : timer_q - TW'(1);
      pending_d = expire ? 1'b1 : (consume ? 1'b0 : pending_q);
      overrun_d = expire & pending_q;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q        <= ST_IDLE;
         addr_val_q     <= 1'b0;
         bank_q         <= '0;
         row_q          <= '0;
         col_q          <= '0;
         grant_id_q     <= '0;
         req_gnt_q      <= '0;
         refresh_flag_q <= 1'b0;
         overrun_q      <= 1'b0;
         pending_q      <= 1'b0;
         timer_q        <= TIMER_RELOAD;
         hold_q         <= '0;
      end else begin
         state_q        <= state_d;
         addr_val_q     <= addr_val_d;
         bank_q         <= bank_d;
         row_q          <= row_d;
         col_q          <= col_d;
         grant_id_q     <= grant_id_d;
         req_gnt_q      <= req_gnt_d;
         refresh_flag_q <= refresh_flag_d;
         overrun_q      <= overrun_d;
         pending_q      <= pending_d;
         timer_q        <= timer_d;
         hold_q         <= hold_d;
      end
   end

   assign addr_val        = addr_val_q;
   assign bank_id         = bank_q;
   assign row_id          = row_q;
   assign col_id          = col_q;
   assign grant_id        = grant_id_q;
   assign req_gnt         = req_gnt_q;
   assign refresh_flag    = refresh_flag_q;
   assign refresh_overrun = overrun_q;

endmodule

// File: tb/tb_dram_req_scheduler.sv
// Directed self-checking bench for dram_req_scheduler with a 64-cycle refresh interval.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dram_req_scheduler;

   localparam int NREQ = 4;
   localparam int BW_T = 3;
   localparam int RW_T = 7;
   localparam int CW_T = 3;

   logic                 clk;
   logic                 rst_b;
   logic [NREQ-1:0]      req_val;
   logic [NREQ*BW_T-1:0] req_bank;
   logic [NREQ*RW_T-1:0] req_row;
   logic [NREQ*CW_T-1:0] req_col;
   logic [NREQ-1:0]      req_gnt;
   logic                 cmd_done;
   logic                 addr_val;
   logic [BW_T-1:0]      bank_id;
   logic [RW_T-1:0]      row_id;
   logic [CW_T-1:0]      col_id;
   logic                 refresh_flag;
   logic [1:0]           grant_id;
   logic                 refresh_overrun;

   int vectors;
   int miscompares;

   dram_req_scheduler #(
      .NUMBER_OF_BANKS  (8),
      .NUMBER_OF_ROWS   (128),
      .NUMBER_OF_COLS   (8),
      .NUM_REQ          (NREQ),
      .REFRESH_INTERVAL (64),
      .REFRESH_CYCLES   (16)
   ) dut (
      .clk             (clk),
      .rst_b           (rst_b),
      .req_val         (req_val),
      .req_bank        (req_bank),
      .req_row         (req_row),
      .req_col         (req_col),
      .req_gnt         (req_gnt),
      .cmd_done        (cmd_done),
      .addr_val        (addr_val),
      .bank_id         (bank_id),
      .row_id          (row_id),
      .col_id          (col_id),
      .refresh_flag    (refresh_flag),
      .grant_id        (grant_id),
      .refresh_overrun (refresh_overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic set_req(input int i, input logic [BW_T-1:0] b, input logic [RW_T-1:0] r,
                          input logic [CW_T-1:0] c);
      req_bank[i*BW_T +: BW_T] = b;
      req_row[i*RW_T +: RW_T]  = r;
      req_col[i*CW_T +: CW_T]  = c;
   endtask

   // Leaves the bench at the falling edge where reset is released (cycle 0).
   task automatic do_reset();
      @(negedge clk);
      rst_b    = 1'b0;
      req_val  = '0;
      req_bank = '0;
      req_row  = '0;
      req_col  = '0;
      cmd_done = 1'b0;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] outs;
      @(negedge clk);
      rst_b    = 1'b0;
      req_val  = '0;
      req_bank = '0;
      req_row  = '0;
      req_col  = '0;
      cmd_done = 1'b0;
      #1;
      outs = {addr_val, req_gnt, refresh_flag, refresh_overrun, bank_id, row_id, col_id, grant_id};
      vectors++;
      if (outs !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got %0h expected 0", outs);
      end
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         outs = {addr_val, req_gnt, refresh_flag, refresh_overrun, bank_id, row_id, col_id, grant_id};
         vectors++;
         if (outs !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL idle_outputs c=%0d: got %0h expected 0", c, outs);
         end
      end
   endtask

   task automatic test_single_request();
      do_reset();
      req_val = 4'b0100;
      set_req(2, 3'd5, 7'd77, 3'd3);
      @(negedge clk);
      vectors++;
      if ({req_gnt, addr_val, bank_id, row_id, col_id, grant_id} !== {4'b0100, 1'b1, 3'd5, 7'd77, 3'd3, 2'd2}) begin
         miscompares++;
         $display("[TB] FAIL single_grant: got gnt=%b av=%b b=%0d r=%0d c=%0d g=%0d expected gnt=0100 av=1 b=5 r=77 c=3 g=2",
                  req_gnt, addr_val, bank_id, row_id, col_id, grant_id);
      end
      // Another requester shows up with different fields while the command is held.
      req_val = 4'b0001;
      set_req(0, 3'd1, 7'd1, 3'd1);
      for (int c = 2; c <= 6; c++) begin
         @(negedge clk);
         vectors++;
         if ({req_gnt, addr_val, bank_id, row_id, col_id, grant_id} !== {4'b0000, 1'b1, 3'd5, 7'd77, 3'd3, 2'd2}) begin
            miscompares++;
            $display("[TB] FAIL single_hold c=%0d: got gnt=%b av=%b b=%0d r=%0d c=%0d g=%0d expected gnt=0000 av=1 b=5 r=77 c=3 g=2",
                     c, req_gnt, addr_val, bank_id, row_id, col_id, grant_id);
         end
         if (c == 5) req_val = '0;
         if (c == 6) cmd_done = 1'b1;
      end
      @(negedge clk);
      cmd_done = 1'b0;
      vectors++;
      if ({req_gnt, addr_val, bank_id, row_id, col_id, grant_id} !== {4'b0000, 1'b0, 3'd5, 7'd77, 3'd3, 2'd2}) begin
         miscompares++;
         $display("[TB] FAIL single_done: got gnt=%b av=%b b=%0d r=%0d c=%0d g=%0d expected gnt=0000 av=0 b=5 r=77 c=3 g=2",
                  req_gnt, addr_val, bank_id, row_id, col_id, grant_id);
      end
      @(negedge clk);
      vectors++;
      if ({req_gnt, addr_val} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL single_idle_after: got gnt=%b av=%b expected 0000/0", req_gnt, addr_val);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_gnt;
      logic [2:0] exp_bank;
      logic [6:0] exp_row;
      logic [2:0] exp_col;
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         set_req(i, 3'(i + 4), 7'(20 * i + 3), 3'(7 - i));
      end
      req_val = 4'b1111;
      @(negedge clk);
      for (int g = 0; g < 5; g++) begin
         exp_gnt  = 4'b0001 << (g % 4);
         exp_bank = 3'((g % 4) + 4);
         exp_row  = 7'(20 * (g % 4) + 3);
         exp_col  = 3'(7 - (g % 4));
         vectors++;
         if ({req_gnt, addr_val, grant_id, bank_id, row_id, col_id} !==
             {exp_gnt, 1'b1, 2'(g % 4), exp_bank, exp_row, exp_col}) begin
            miscompares++;
            $display("[TB] FAIL rr_grant %0d: got gnt=%b av=%b g=%0d b=%0d r=%0d c=%0d expected gnt=%b av=1 g=%0d b=%0d r=%0d c=%0d",
                     g, req_gnt, addr_val, grant_id, bank_id, row_id, col_id, exp_gnt, g % 4, exp_bank, exp_row, exp_col);
         end
         for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
               vectors++;
               if (req_gnt !== 4'b0000) begin
                  miscompares++;
                  $display("[TB] FAIL rr_pulse %0d: got gnt=%b expected 0000", g, req_gnt);
               end
            end
         end
         cmd_done = 1'b1;
         @(negedge clk);
         cmd_done = 1'b0;
         vectors++;
         if ({addr_val, req_gnt} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL rr_gap %0d: got av=%b gnt=%b expected 0/0000", g, addr_val, req_gnt);
         end
         @(negedge clk);
      end
      req_val = '0;
   endtask

   task automatic test_refresh_priority();
      int addr_run;
      int flag_run;
      int starts;
      int start0;
      int start1;
      addr_run = 0;
      flag_run = 0;
      starts   = 0;
      start0   = -1;
      start1   = -1;
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         set_req(i, 3'(i), 7'(i + 40), 3'(i));
      end
      req_val = 4'b1111;
      for (int c = 1; c <= 160; c++) begin
         @(negedge clk);
         vectors++;
         if ((refresh_flag && addr_val) || refresh_overrun !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL refresh_excl c=%0d: got rf=%b av=%b ovr=%b expected no overlap, ovr=0",
                     c, refresh_flag, addr_val, refresh_overrun);
         end
         if (addr_val) begin
            addr_run++;
         end else if (addr_run != 0) begin
            vectors++;
            if (addr_run !== 4) begin
               miscompares++;
               $display("[TB] FAIL cmd_length c=%0d: got %0d cycles expected 4", c, addr_run);
            end
            addr_run = 0;
         end
         if (refresh_flag) begin
            if (flag_run == 0) begin
               if (starts == 0) start0 = c;
               if (starts == 1) start1 = c;
               starts++;
            end
            flag_run++;
         end else if (flag_run != 0) begin
            vectors++;
            if (flag_run !== 16) begin
               miscompares++;
               $display("[TB] FAIL refresh_length c=%0d: got %0d cycles expected 16", c, flag_run);
            end
            flag_run = 0;
         end
         cmd_done = (addr_run == 4);
      end
      cmd_done = 1'b0;
      req_val  = '0;
      vectors++;
      if (starts !== 2 || start0 !== 66 || start1 !== 133) begin
         miscompares++;
         $display("[TB] FAIL refresh_starts: got n=%0d at %0d,%0d expected n=2 at 66,133", starts, start0, start1);
      end
   endtask

   task automatic test_overrun();
      int pulses;
      logic exp_ovr;
      logic exp_rf;
      pulses = 0;
      do_reset();
      req_val = 4'b0010;
      set_req(1, 3'd2, 7'd9, 3'd6);
      @(negedge clk);
      req_val = '0;
      vectors++;
      if ({req_gnt, addr_val, grant_id} !== {4'b0010, 1'b1, 2'd1}) begin
         miscompares++;
         $display("[TB] FAIL ovr_grant: got gnt=%b av=%b g=%0d expected 0010/1/1", req_gnt, addr_val, grant_id);
      end
      for (int c = 2; c <= 250; c++) begin
         @(negedge clk);
         exp_ovr = (c == 128) || (c == 192);
         exp_rf  = (c >= 202) && (c <= 217);
         if (refresh_overrun) pulses++;
         vectors++;
         if ({refresh_overrun, refresh_flag, addr_val} !== {exp_ovr, exp_rf, (c <= 200)}) begin
            miscompares++;
            $display("[TB] FAIL overrun_seq c=%0d: got ovr=%b rf=%b av=%b expected ovr=%b rf=%b av=%b",
                     c, refresh_overrun, refresh_flag, addr_val, exp_ovr, exp_rf, (c <= 200));
         end
         cmd_done = (c == 200);
      end
      vectors++;
      if (pulses !== 2) begin
         miscompares++;
         $display("[TB] FAIL overrun_count: got %0d expected 2", pulses);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req_val = 4'b0100;
      set_req(2, 3'd6, 7'd100, 3'd7);
      @(negedge clk);
      vectors++;
      if ({req_gnt, addr_val} !== {4'b0100, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL areset_pre: got gnt=%b av=%b expected 0100/1", req_gnt, addr_val);
      end
      req_val = '0;
      #2;
      rst_b = 1'b0;
      #1;
      vectors++;
      if ({addr_val, req_gnt, refresh_flag, grant_id} !== 8'b0) begin
         miscompares++;
         $display("[TB] FAIL areset_immediate: got av=%b gnt=%b rf=%b g=%0d expected all 0",
                  addr_val, req_gnt, refresh_flag, grant_id);
      end
      for (int i = 0; i < NREQ; i++) begin
         set_req(i, 3'(i + 1), 7'(i + 11), 3'(i + 2));
      end
      req_val = 4'b1111;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      vectors++;
      if ({req_gnt, addr_val, grant_id, bank_id, row_id} !== {4'b0001, 1'b1, 2'd0, 3'd1, 7'd11}) begin
         miscompares++;
         $display("[TB] FAIL areset_first_grant: got gnt=%b av=%b g=%0d b=%0d r=%0d expected 0001/1/0/1/11",
                  req_gnt, addr_val, grant_id, bank_id, row_id);
      end
      req_val = '0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_b       = 1'b1;
      req_val     = '0;
      req_bank    = '0;
      req_row     = '0;
      req_col     = '0;
      cmd_done    = 1'b0;
      test_reset();
      test_single_request();
      test_round_robin();
      test_refresh_priority();
      test_overrun();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
